// File: rtl/ahb_master_if.sv
// Single-transfer AHB-Lite master: takes one core request, arbitrates for the bus,
// runs one NONSEQ SINGLE transfer and returns read data or an error.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a core request, req_ready high
// S_REQ  | HBUSREQ asserted, waiting for HGRANT && HREADY
// S_ADDR | address phase, NONSEQ driven until HREADY
// S_DATA | data phase, waiting for HREADY, then decode HRESP
module ahb_master_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 15
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_size,
    input  logic              req_lock,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              HBUSREQ,
    output logic              HLOCK,
    input  logic              HGRANT,
    output logic [1:0]        HTRANS,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ADDR = 2'd2,
        S_DATA = 2'd3
    } state_t;

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [3:0] RETRY_LOAD = 4'(MAX_RETRY);

    state_t            state;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        size_q;
    logic              lock_q;
    // Down-counter of retries still allowed; terminal count zero turns the next RETRY/SPLIT into an error.
    logic [3:0]        retry_left;

    assign HBURST = 3'b000;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= S_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 3'd0;
            lock_q     <= 1'b0;
            retry_left <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            HBUSREQ    <= 1'b0;
            HLOCK      <= 1'b0;
            HTRANS     <= TR_IDLE;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HSIZE      <= 3'd0;
            HWDATA     <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q       <= req_write;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        lock_q     <= req_lock;
                        retry_left <= RETRY_LOAD;
                        req_ready  <= 1'b0;
                        HBUSREQ    <= 1'b1;
                        HLOCK      <= req_lock;
                        HTRANS     <= TR_IDLE;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (HGRANT && HREADY) begin
                        HTRANS <= TR_NONSEQ;
                        HADDR  <= addr_q;
                        HWRITE <= wr_q;
                        HSIZE  <= size_q;
                        state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        HTRANS  <= TR_IDLE;
                        HBUSREQ <= 1'b0;
                        HLOCK   <= 1'b0;
                        HWDATA  <= wr_q ? wdata_q : '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        HWDATA <= '0;
                        if (HRESP == RESP_OKAY) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= wr_q ? '0 : HRDATA;
                            req_ready  <= 1'b1;
                            state      <= S_IDLE;
                        end else if (HRESP == RESP_ERROR || retry_left == 4'd0) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            req_ready  <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            // RETRY/SPLIT: re-arbitrate and reissue the same transfer
                            retry_left <= retry_left - 4'd1;
                            HBUSREQ    <= 1'b1;
                            HLOCK      <= lock_q;
                            state      <= S_REQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_if.sv
// Randomized bench for ahb_master_if: a reactive arbiter/slave driver plus a
// scoreboard whose expectations come from per-transaction arithmetic.
module tb_ahb_master_if;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MR = 2;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          req_valid, req_ready, req_write, req_lock;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [2:0]    req_size;
    logic          resp_valid, resp_err;
    logic [DW-1:0] resp_rdata;
    logic          HBUSREQ, HLOCK, HGRANT, HWRITE, HREADY;
    logic [1:0]    HTRANS, HRESP;
    logic [AW-1:0] HADDR;
    logic [2:0]    HSIZE, HBURST;
    logic [DW-1:0] HWDATA, HRDATA;

    always #5 HCLK = ~HCLK;

    ahb_master_if #(.ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(MR)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_lock(req_lock),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HGRANT(HGRANT), .HTRANS(HTRANS),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [2:0]    size;
        logic          lock;
        logic          err;
        int            lat;
        int            nns;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   gd[4], aw[4], dw[4];

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic abort_run(input string what);
        total++;
        $display("FAIL timeout_%s: cycle bound expired, expected DUT progress", what);
        $display("%0d/%0d checks passed", passed, total);
        $fatal(1, "aborting run");
    endtask

    // Monitor: pops the scoreboard on each response and checks bus-side behaviour.
    logic data_ph = 1'b0, prev_ns = 1'b0, prev_gr = 1'b0;
    int   acc_cyc = 0, ns_cnt = 0;
    always @(negedge HCLK) begin
        if (HRESET) begin
            data_ph = 1'b0;
            prev_ns = 1'b0;
            prev_gr = 1'b0;
            ns_cnt  = 0;
        end else begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_resp: resp_valid=1, expected 0");
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_err", resp_err, mon_e.err);
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("latency", cyc - acc_cyc + 1, mon_e.lat);
                    chk("nonseq_count", ns_cnt, mon_e.nns);
                    chk("req_ready_with_resp", req_ready, 1'b1);
                end
                ns_cnt = 0;
            end
            if (data_ph && sb.size() > 0) begin
                chk("htrans_data", HTRANS, 2'b00);
                chk("hbusreq_data", HBUSREQ, 1'b0);
                chk("hwdata", HWDATA, sb[0].wr ? sb[0].wdata : 32'h0);
                if (HREADY) data_ph = 1'b0;
            end
            if (HTRANS == 2'b10) begin
                if (sb.size() > 0) begin
                    chk("haddr", HADDR, sb[0].addr);
                    chk("hwrite", HWRITE, sb[0].wr);
                    chk("hsize", HSIZE, sb[0].size);
                end
                if (!prev_ns) chk("grant_before_nonseq", prev_gr, 1'b1);
                if (HREADY) begin
                    ns_cnt++;
                    data_ph = 1'b1;
                end
            end
            if (HBUSREQ && sb.size() > 0) chk("hlock_req", HLOCK, sb[0].lock);
            else if (!HBUSREQ) chk("hlock_released", HLOCK, 1'b0);
            chk("hburst", HBURST, 3'b000);
            if (req_valid && req_ready) acc_cyc = cyc + 1;
            prev_ns = (HTRANS == 2'b10);
            prev_gr = HGRANT && HREADY;
        end
    end

    task automatic check_reset_vals();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_hbusreq", HBUSREQ, 1'b0);
        chk("rst_hlock", HLOCK, 1'b0);
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_hsize", HSIZE, 3'd0);
        chk("rst_hburst", HBURST, 3'd0);
        chk("rst_hwdata", HWDATA, 32'h0);
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [2:0] size, input logic lock);
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_lock  = lock;
        req_valid = 1'b1;
        for (int i = 0; !req_ready; i++) begin
            if (i >= 20) abort_run("req_ready");
            tick();
        end
        tick();
        req_valid = 1'b0;
        req_write = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 3'($urandom_range(0, 7));
        req_lock  = $urandom_range(0, 1);
    endtask

    task automatic wait_nonseq();
        for (int i = 0; ; i++) begin
            if (i >= 20) abort_run("nonseq");
            tick();
            if (HTRANS == 2'b10) break;
        end
    endtask

    // One transfer: nret RETRY/SPLIT responses, then OKAY or ERROR (ferr).
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] rdata, input logic [2:0] size, input logic lock,
                           input int nret, input logic ferr);
        exp_t e;
        int   att;
        att = (nret > MR) ? MR + 1 : nret + 1;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.size = size; e.lock = lock;
        e.err = (nret > MR) || ferr;
        e.rdata = (!e.err && !wr) ? rdata : 32'h0;
        e.nns = att;
        e.lat = 1;
        for (int k = 0; k < att; k++) e.lat += 3 + gd[k] + aw[k] + dw[k];
        sb.push_back(e);
        issue(wr, addr, wdata, size, lock);
        for (int k = 0; k < att; k++) begin
            HRESP  = 2'b00;
            HREADY = 1'b1;
            HGRANT = 1'b0;
            repeat (gd[k]) tick();
            HGRANT = 1'b1;
            wait_nonseq();
            for (int w = 0; w < aw[k]; w++) begin
                HREADY = 1'b0;
                tick();
            end
            HREADY = 1'b1;
            tick();
            for (int w = 0; w < dw[k]; w++) begin
                HREADY = 1'b0;
                HRESP  = 2'($urandom_range(0, 3));
                HRDATA = $urandom;
                tick();
            end
            HREADY = 1'b1;
            HRDATA = rdata;
            if (k < nret) HRESP = 2'b10 | 2'($urandom_range(0, 1));
            else          HRESP = ferr ? 2'b01 : 2'b00;
            tick();
        end
        HRESP  = 2'b00;
        HRDATA = $urandom;
        HGRANT = $urandom_range(0, 1);
    endtask

    task automatic set_delays(input int g0, input int a0, input int d0);
        for (int k = 0; k < 4; k++) begin
            gd[k] = g0; aw[k] = a0; dw[k] = d0;
        end
    endtask

    initial begin
        HRESET = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 3'd0; req_lock = 1'b0;
        HGRANT = 1'b0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
        tick();
        tick();
        check_reset_vals();
        HRESET = 1'b0;
        tick();

        set_delays(0, 0, 0);
        run_txn(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 3'd2, 1'b0, 0, 1'b0);
        set_delays(0, 0, 0); gd[0] = 3; dw[0] = 2;
        run_txn(1'b0, 32'h2000_0010, 32'h0, 32'h1234_5678, 3'd2, 1'b0, 0, 1'b0);
        set_delays(0, 0, 1);
        run_txn(1'b1, 32'h3000_0000, 32'hCAFE_F00D, 32'h0, 3'd1, 1'b0, 0, 1'b1);
        set_delays(1, 0, 0);
        run_txn(1'b0, 32'h4000_0008, 32'h0, 32'hA5A5_5A5A, 3'd2, 1'b0, 2, 1'b0);
        set_delays(0, 1, 0);
        run_txn(1'b0, 32'h5000_000C, 32'h0, 32'h0BAD_0BAD, 3'd0, 1'b0, MR + 1, 1'b0);
        set_delays(1, 1, 1);
        run_txn(1'b0, 32'h6000_0002, 32'h0, 32'h7777_1111, 3'd1, 1'b1, 1, 1'b0);

        for (int t = 0; t < 60; t++) begin
            int nret;
            for (int k = 0; k < 4; k++) begin
                gd[k] = $urandom_range(0, 3);
                aw[k] = $urandom_range(0, 2);
                dw[k] = $urandom_range(0, 2);
            end
            nret = ($urandom_range(0, 2) == 0) ? $urandom_range(1, MR + 1) : 0;
            run_txn($urandom_range(0, 1), $urandom, $urandom, $urandom,
                    3'($urandom_range(0, 2)), $urandom_range(0, 1), nret,
                    $urandom_range(0, 4) == 0);
        end

        // Reset while the data phase is stalled: transfer is dropped silently.
        set_delays(0, 0, 0);
        issue(1'b1, 32'h7000_0000, 32'h1111_2222, 3'd2, 1'b1);
        HGRANT = 1'b1;
        HREADY = 1'b1;
        wait_nonseq();
        tick();
        HREADY = 1'b0;
        chk("pre_reset_in_data", HTRANS, 2'b00);
        HRESET = 1'b1;
        tick();
        sb.delete();
        check_reset_vals();
        HRESET = 1'b0;
        HREADY = 1'b1;
        repeat (4) begin
            tick();
            chk("no_resp_after_reset", resp_valid, 1'b0);
        end
        run_txn(1'b0, 32'h8000_0004, 32'h0, 32'h5555_AAAA, 3'd2, 1'b0, 0, 1'b0);

        repeat (5) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        abort_run("global");
    end

endmodule

// File: doc/ahb_master_if.md
# ahb_master_if

Single-transfer AHB-Lite-style master interface that turns one core-side request into one AHB bus transaction. It sits directly upstream of the bus arbiter: it raises `HBUSREQ`/`HLOCK`, waits for its `HGRANT`, then drives the address and data phases and returns read data or an error to the core. One instance per bus master (M1, M2); the default master (M0) does not use it.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_RETRY`, 15, number of RETRY/SPLIT responses tolerated before the transfer is reported as error; 4-bit counter

Ports:
- `HCLK`  in  1  bus clock; all logic on rising edge
- `HRESET`  in  1  synchronous, active-high reset
- `req_valid`  in  1  core request valid
- `req_ready`  out  1  block can accept a request (high only in IDLE)
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  transfer address
- `req_wdata`  in  DATA_W  write data
- `req_size`  in  3  HSIZE encoding (0 = byte, 1 = half, 2 = word)
- `req_lock`  in  1  request locked access
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  DATA_W  read data, valid with `resp_valid` (0 for writes)
- `resp_err`  out  1  transfer failed, valid with `resp_valid`
- `HBUSREQ`  out  1  bus request to arbiter
- `HLOCK`  out  1  lock request to arbiter
- `HGRANT`  in  1  grant from arbiter
- `HTRANS`  out  2  00 IDLE, 10 NONSEQ
- `HADDR`  out  ADDR_W  address
- `HWRITE`  out  1  direction
- `HSIZE`  out  3  size
- `HBURST`  out  3  constant 000 (SINGLE)
- `HWDATA`  out  DATA_W  write data
- `HRDATA`  in  DATA_W  read data
- `HREADY`  in  1  transfer done / bus ready
- `HRESP`  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT

## Operation
- States: IDLE, REQ, ADDR, DATA.
- IDLE: `req_ready`=1. On `req_valid` at an edge, latch write/addr/wdata/size/lock, clear retry counter, go to REQ.
- REQ: `HBUSREQ`=1, `HLOCK`=latched lock, `HTRANS`=IDLE. At edge with `HGRANT`&&`HREADY` go to ADDR.
- ADDR: `HTRANS`=NONSEQ, `HADDR/HWRITE/HSIZE` from latched values, `HBUSREQ` still 1. At edge with `HREADY` go to DATA; else hold all outputs.
- DATA: `HTRANS`=IDLE, `HBUSREQ`=0, `HLOCK`=0, `HWDATA`=latched wdata (writes; 0 for reads). At edge with `HREADY`:
  - `HRESP`=OKAY: `resp_valid`=1 next cycle, `resp_rdata`=`HRDATA` sampled (reads), `resp_err`=0; go to IDLE.
  - `HRESP`=ERROR: `resp_valid`=1, `resp_err`=1, `resp_rdata`=0; go to IDLE.
  - `HRESP`=RETRY/SPLIT: if retry count < `MAX_RETRY`, increment and go to REQ (same transfer reissued); else report as ERROR and go to IDLE.
- `HRESP` sampled only when `HREADY`=1; first (HREADY=0) cycle of a two-cycle response ignored except that `HTRANS` is already IDLE.
- `resp_*` are registered; `resp_rdata`/`resp_err` hold until next completion.

## Timing
- Reset (HRESET=1 at edge): state IDLE, retry count 0; outputs `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `HBUSREQ`=0, `HLOCK`=0, `HTRANS`=00, `HADDR`=0, `HWRITE`=0, `HSIZE`=0, `HBURST`=0, `HWDATA`=0.
- Reset mid-transfer: transfer dropped, no `resp_valid` pulse.
- Best-case latency, grant already held, zero wait states: accept edge E0; REQ during E0→E1; ADDR E1→E2; DATA E2→E3; `resp_valid` high E3→E4. 4 cycles accept-to-response.
- Each HREADY=0 cycle in ADDR or DATA adds one cycle; each cycle without grant in REQ adds one cycle.
- Back-to-back: `req_ready` is high the same cycle `resp_valid` pulses; next request is accepted in that cycle.
- Grant loss in REQ: stay in REQ; no NONSEQ is ever driven without `HGRANT`&&`HREADY` sampled first.

## Test plan
- Write, grant immediate, zero waits: addr 0x1000_0004, data 0xDEADBEEF -> one NONSEQ cycle with HWRITE=1, HWDATA=0xDEADBEEF next cycle, `resp_valid` 4 cycles after accept, `resp_err`=0.
- Read with HGRANT delayed 3 cycles and 2 HREADY=0 data-phase waits, HRDATA=0x12345678 -> HBUSREQ held 3 extra cycles, `resp_rdata`=0x12345678, total latency 9.
- Two-cycle ERROR response on write -> HTRANS=IDLE during both cycles, `resp_valid`=1 with `resp_err`=1, state IDLE.
- RETRY twice then OKAY -> transfer reissued twice (3 NONSEQ cycles at same address), single `resp_valid`, `resp_err`=0; with MAX_RETRY=1, second RETRY -> `resp_err`=1.
- `req_lock`=1 -> HLOCK=1 in REQ and ADDR, 0 in DATA and IDLE.
- HRESET asserted in DATA -> next cycle all outputs at reset values, no `resp_valid`, `req_ready`=1.
